hs32_mem_arbiter: RTL and testbench

//  Shares the single external memory bus between instruction fetch (read-only) and the

---
 rtl/hs32_mem_arbiter_pkg.sv | 24 ++
 rtl/hs32_mem_arbiter_if.sv | 37 +++
 rtl/hs32_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_hs32_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs32_mem_arbiter_pkg : state and grant encodings for the memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package hs32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GF   = 2'd1,
    ST_GX   = 2'd2
  } state_t;

  localparam logic [1:0] c_GNT_NONE  = 2'b00;
  localparam logic [1:0] c_GNT_FETCH = 2'b01;
  localparam logic [1:0] c_GNT_EXEC  = 2'b10;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs32_mem_arbiter_if : requester and memory-side signals of the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface hs32_mem_arbiter_if;

  logic        f_req;
  logic [31:0] f_addr;
  logic        f_rdy;
  logic        x_req;
  logic        x_rw;
  logic [31:0] x_addr;
  logic [31:0] x_dtw;
  logic        x_rdy;
  logic [31:0] dtr;
  logic        err;
  logic [1:0]  gnt;
  logic        m_req;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_dtw;
  logic [31:0] m_dtr;
  logic        m_rdy;

  modport master (
    input  f_req, f_addr, x_req, x_rw, x_addr, x_dtw, m_dtr, m_rdy,
    output f_rdy, x_rdy, dtr, err, gnt, m_req, m_rw, m_addr, m_dtw
  );

  modport slave (
    output f_req, f_addr, x_req, x_rw, x_addr, x_dtw, m_dtr, m_rdy,
    input  f_rdy, x_rdy, dtr, err, gnt, m_req, m_rw, m_addr, m_dtw
  );

endinterface
`default_nettype wire

// File: rtl/hs32_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs32_mem_arbiter : shares the memory bus between fetch and execute, exec
// priority with a starvation guard for fetch and an optional bus watchdog.
// Rev 1.0
// ----------------------------------------------------------------------------
module hs32_mem_arbiter
  import hs32_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  wire logic          clk,
  input  wire logic          reset,
  hs32_mem_arbiter_if.master bus
);

  localparam int              c_SW         = cnt_width(STARVE_MAX);
  localparam int              c_WW         = cnt_width(TIMEOUT);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);
  localparam logic [c_WW-1:0] c_WDOG_LAST  = (TIMEOUT == 0) ? '0 : c_WW'(TIMEOUT - 1);
  localparam logic            c_WDOG_EN    = (TIMEOUT != 0);

  state_t          r_state,  w_state;
  logic            r_m_req,  w_m_req;
  logic            r_m_rw,   w_m_rw;
  logic [31:0]     r_m_addr, w_m_addr;
  logic [31:0]     r_m_dtw,  w_m_dtw;
  logic [1:0]      r_gnt,    w_gnt;
  logic [c_SW-1:0] r_starve, w_starve;
  logic [c_WW-1:0] r_wdog,   w_wdog;

  logic w_owned;
  logic w_done;
  logic w_timeout;
  logic w_finish;
  logic w_pick_fetch;

  assign w_owned      = (r_state != ST_IDLE);
  assign w_done       = w_owned && r_m_req && bus.m_rdy;
  // A memory response in the last watchdog cycle takes precedence over the abort.
  assign w_timeout    = c_WDOG_EN && w_owned && !w_done && (r_wdog == c_WDOG_LAST);
  assign w_finish     = w_done || w_timeout;
  assign w_pick_fetch = bus.f_req && (!bus.x_req || (r_starve == c_STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_m_req  <= 1'b0;
      r_m_rw   <= 1'b0;
      r_m_addr <= '0;
      r_m_dtw  <= '0;
      r_gnt    <= c_GNT_NONE;
      r_starve <= '0;
      r_wdog   <= '0;
    end else begin
      r_state  <= w_state;
      r_m_req  <= w_m_req;
      r_m_rw   <= w_m_rw;
      r_m_addr <= w_m_addr;
      r_m_dtw  <= w_m_dtw;
      r_gnt    <= w_gnt;
      r_starve <= w_starve;
      r_wdog   <= w_wdog;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_m_req  = r_m_req;
    w_m_rw   = r_m_rw;
    w_m_addr = r_m_addr;
    w_m_dtw  = r_m_dtw;
    w_gnt    = r_gnt;
    w_starve = r_starve;
    w_wdog   = r_wdog;

    case (r_state)
      ST_IDLE: begin
        w_wdog = '0;
        if (!bus.f_req) begin
          w_starve = '0;
        end
        if (bus.f_req || bus.x_req) begin
          w_m_req = 1'b1;
          if (w_pick_fetch) begin
            w_state  = ST_GF;
            w_gnt    = c_GNT_FETCH;
            w_m_addr = bus.f_addr;
            w_m_rw   = 1'b0;
            w_m_dtw  = '0;
            w_starve = '0;
          end else begin
            w_state  = ST_GX;
            w_gnt    = c_GNT_EXEC;
            w_m_addr = bus.x_addr;
            w_m_rw   = bus.x_rw;
            w_m_dtw  = bus.x_dtw;
            if (bus.f_req && (r_starve != c_STARVE_MAX)) begin
              w_starve = r_starve + 1'b1;
            end
          end
        end
      end
      ST_GF, ST_GX: begin
        if (w_finish) begin
          w_state = ST_IDLE;
          w_m_req = 1'b0;
          w_gnt   = c_GNT_NONE;
          w_wdog  = '0;
        end else begin
          w_wdog  = r_wdog + 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_m_req = 1'b0;
        w_gnt   = c_GNT_NONE;
        w_wdog  = '0;
      end
    endcase
  end

  assign bus.f_rdy  = (r_state == ST_GF) && w_finish;
  assign bus.x_rdy  = (r_state == ST_GX) && w_finish;
  assign bus.err    = w_timeout;
  assign bus.dtr    = w_timeout ? 32'd0 : bus.m_dtr;
  assign bus.gnt    = r_gnt;
  assign bus.m_req  = r_m_req;
  assign bus.m_rw   = r_m_rw;
  assign bus.m_addr = r_m_addr;
  assign bus.m_dtw  = r_m_dtw;

`ifdef FORMAL
  // A requester must hold its request until served; the grant is never revoked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.f_rdy && bus.x_rdy));
      if (bus.f_rdy) assert (r_state == ST_GF);
      if (bus.x_rdy) assert (r_state == ST_GX);
      if (r_state == ST_GF) assert (bus.f_req);
      if (r_state == ST_GX) assert (bus.x_req);
      if (r_m_req && !w_finish) assert (w_m_addr == r_m_addr && w_m_dtw == r_m_dtw && w_m_rw == r_m_rw);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs32_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hs32_mem_arbiter : directed scoreboard bench for hs32_mem_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hs32_mem_arbiter;
  import hs32_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct packed {
    logic        f;
    logic        x;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  hs32_mem_arbiter_if bus();

  hs32_mem_arbiter #(
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=still running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb observed=empty queue expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_f_rdy"}, 32'(bus.f_rdy), 32'(e.f));
    chk({tag, "_x_rdy"}, 32'(bus.x_rdy), 32'(e.x));
    chk({tag, "_dtr"},   bus.dtr,        e.data);
    chk({tag, "_err"},   32'(bus.err),   32'(e.err));
  endtask

  // Called #1 after the negedge of the first owned cycle.
  task automatic serve(input string tag, input int lat, input logic [31:0] data,
                       input logic [1:0] owner, input logic drop);
    for (int i = 0; i < lat; i++) begin
      bus.m_rdy = 1'b0;
      #1;
      chk({tag, "_no_rdy"}, 32'({bus.f_rdy, bus.x_rdy}), 32'd0);
      @(negedge clk);
    end
    bus.m_rdy = 1'b1;
    bus.m_dtr = data;
    sb.push_back('{f: (owner == c_GNT_FETCH), x: (owner == c_GNT_EXEC), data: data, err: 1'b0});
    #1;
    sb_check(tag);
    @(negedge clk);
    bus.m_rdy = 1'b0;
    if (drop) begin
      if (owner == c_GNT_FETCH) bus.f_req = 1'b0;
      else                      bus.x_req = 1'b0;
    end
    #1;
    chk({tag, "_idle_mreq"}, 32'(bus.m_req), 32'd0);
    chk({tag, "_idle_gnt"},  32'(bus.gnt),   32'(c_GNT_NONE));
  endtask

  task automatic wait_rdy(input string tag, input int budget, output int cyc);
    cyc = 1;
    #1;
    while (!(bus.f_rdy || bus.x_rdy) && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!(bus.f_rdy || bus.x_rdy)) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_wait observed=no rdy expected=rdy within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    bus.f_req  = 1'b0;
    bus.f_addr = '0;
    bus.x_req  = 1'b0;
    bus.x_rw   = 1'b0;
    bus.x_addr = '0;
    bus.x_dtw  = '0;
    bus.m_dtr  = '0;
    bus.m_rdy  = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_m_req",  32'(bus.m_req), 32'd0);
    chk("rst_gnt",    32'(bus.gnt),   32'd0);
    chk("rst_m_addr", bus.m_addr,     32'd0);
    chk("rst_m_dtw",  bus.m_dtw,      32'd0);
    chk("rst_m_rw",   32'(bus.m_rw),  32'd0);
    chk("rst_rdy",    32'({bus.f_rdy, bus.x_rdy, bus.err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Stray m_rdy with no request is ignored
    @(negedge clk);
    bus.m_rdy = 1'b1;
    bus.m_dtr = 32'h77;
    #1;
    chk("stray_rdy", 32'({bus.f_rdy, bus.x_rdy}), 32'd0);
    @(negedge clk);
    bus.m_rdy = 1'b0;
    #1;
    chk("stray_mreq", 32'(bus.m_req), 32'd0);

    // 1: single fetch, memory answers two cycles after m_req
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h100;
    #1;
    chk("t1_mreq_n", 32'(bus.m_req), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_mreq_n1", 32'(bus.m_req), 32'd1);
    chk("t1_gnt",     32'(bus.gnt),   32'(c_GNT_FETCH));
    chk("t1_addr",    bus.m_addr,     32'h100);
    chk("t1_rw",      32'(bus.m_rw),  32'd0);
    serve("t1", 2, 32'hDEADBEEF, c_GNT_FETCH, 1'b1);

    // 2: simultaneous requests, exec wins, fetch after one idle cycle
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h104;
    bus.x_req  = 1'b1;
    bus.x_rw   = 1'b1;
    bus.x_addr = 32'h200;
    bus.x_dtw  = 32'h55;
    #1;
    @(negedge clk);
    #1;
    chk("t2_gnt_x", 32'(bus.gnt),  32'(c_GNT_EXEC));
    chk("t2_rw",    32'(bus.m_rw), 32'd1);
    chk("t2_dtw",   bus.m_dtw,     32'h55);
    chk("t2_addr",  bus.m_addr,    32'h200);
    serve("t2x", 0, 32'h1234, c_GNT_EXEC, 1'b1);
    @(negedge clk);
    #1;
    chk("t2_gnt_f", 32'(bus.gnt),  32'(c_GNT_FETCH));
    chk("t2_faddr", bus.m_addr,    32'h104);
    chk("t2_frw",   32'(bus.m_rw), 32'd0);
    chk("t2_fdtw",  bus.m_dtw,     32'd0);
    serve("t2f", 1, 32'h600DF00D, c_GNT_FETCH, 1'b1);

    // 3: exec held with fetch waiting -> four exec grants then a forced fetch
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h400;
    bus.x_req  = 1'b1;
    bus.x_rw   = 1'b0;
    bus.x_addr = 32'h300;
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (k < 4) begin
        chk("t3_gnt_x", 32'(bus.gnt), 32'(c_GNT_EXEC));
        chk("t3_addr_x", bus.m_addr, 32'h300);
        serve("t3x", 0, 32'h3000 + 32'(k), c_GNT_EXEC, 1'b0);
      end else begin
        chk("t3_gnt_f", 32'(bus.gnt), 32'(c_GNT_FETCH));
        chk("t3_addr_f", bus.m_addr, 32'h400);
        serve("t3f", 0, 32'h4000, c_GNT_FETCH, 1'b0);
      end
      if (k == 3) chk("t3_starve_sat", 32'(dut.r_starve), 32'd4);
    end
    chk("t3_starve_clr", 32'(dut.r_starve), 32'd0);
    bus.f_req = 1'b0;
    bus.x_req = 1'b0;

    // 4: watchdog abort on the eighth owned cycle
    @(negedge clk);
    bus.x_req  = 1'b1;
    bus.x_addr = 32'h500;
    bus.m_dtr  = 32'hFFFFFFFF;
    #1;
    @(negedge clk);
    #1;
    chk("t4_gnt", 32'(bus.gnt), 32'(c_GNT_EXEC));
    sb.push_back('{f: 1'b0, x: 1'b1, data: 32'd0, err: 1'b1});
    @(negedge clk);
    wait_rdy("t4", 20, cyc);
    chk("t4_cycle", 32'(cyc + 1), 32'd8);
    sb_check("t4");
    @(negedge clk);
    bus.x_req = 1'b0;
    #1;
    chk("t4_mreq_low", 32'(bus.m_req), 32'd0);
    chk("t4_err_low",  32'(bus.err),   32'd0);

    // 5: m_rdy on the exact timeout cycle completes normally
    @(negedge clk);
    bus.x_req  = 1'b1;
    bus.x_addr = 32'h600;
    #1;
    @(negedge clk);
    #1;
    chk("t5_gnt", 32'(bus.gnt), 32'(c_GNT_EXEC));
    serve("t5", 7, 32'hCAFEF00D, c_GNT_EXEC, 1'b1);

    // 6: asynchronous reset while exec owns the bus
    @(negedge clk);
    bus.x_req  = 1'b1;
    bus.x_addr = 32'h700;
    #1;
    @(negedge clk);
    #1;
    chk("t6_mreq_on", 32'(bus.m_req), 32'd1);
    chk("t6_gnt_on",  32'(bus.gnt),   32'(c_GNT_EXEC));
    #1;
    reset     = 1'b1;
    bus.m_rdy = 1'b1;
    #1;
    chk("t6_mreq_off", 32'(bus.m_req), 32'd0);
    chk("t6_gnt_off",  32'(bus.gnt),   32'd0);
    chk("t6_no_xrdy",  32'(bus.x_rdy), 32'd0);
    @(negedge clk);
    bus.x_req = 1'b0;
    bus.m_rdy = 1'b0;
    reset     = 1'b0;
    #1;
    chk("t6_idle", 32'(bus.m_req), 32'd0);

    // Bus is usable again after the reset
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h800;
    #1;
    @(negedge clk);
    #1;
    chk("t7_gnt", 32'(bus.gnt), 32'(c_GNT_FETCH));
    serve("t7", 0, 32'h89ABCDEF, c_GNT_FETCH, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
